// File: rtl/bp_cacc_pkg.sv
// Shared definitions for the coherent-accelerator tile: CSR offsets, front-end
// FSM states and STATUS bit positions, used by the config front end and vdp datapath.
package bp_cacc_pkg;

  localparam logic [7:0] e_cacc_reg_a_addr = 8'h00;
  localparam logic [7:0] e_cacc_reg_b_addr = 8'h08;
  localparam logic [7:0] e_cacc_reg_len    = 8'h10;
  localparam logic [7:0] e_cacc_reg_start  = 8'h18;
  localparam logic [7:0] e_cacc_reg_status = 8'h20;
  localparam logic [7:0] e_cacc_reg_result = 8'h28;

  localparam int cacc_status_busy_bit = 0;
  localparam int cacc_status_done_bit = 1;

  typedef enum logic {
    e_ready = 1'b0,
    e_resp  = 1'b1
  } cacc_state_e;

endpackage

// File: rtl/bp_cacc_io_cfg_regs.sv
// Accelerator CSR file: A/B/LEN configuration, start pulse generation and
// busy/done/result tracking of the compute datapath.
module bp_cacc_io_cfg_regs
  import bp_cacc_pkg::*;
#(
  parameter int paddr_width_p = 40,
  parameter int dword_width_p = 64,
  parameter int len_width_p   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fire,
  input  logic                     wr,
  input  logic [7:0]               offset,
  input  logic [paddr_width_p-1:0] wdata,
  output logic [dword_width_p-1:0] rdata,
  output logic                     start,
  output logic [paddr_width_p-1:0] a_addr,
  output logic [paddr_width_p-1:0] b_addr,
  output logic [len_width_p-1:0]   len,
  input  logic                     done,
  input  logic [dword_width_p-1:0] result
);

  logic                     busy_r;
  logic                     done_r;
  logic [dword_width_p-1:0] result_r;
  logic                     cfg_wr;
  logic                     rd_fire;

  // Offsets are compared on all 8 bits, so unaligned addresses never hit a register.
  assign cfg_wr  = fire & wr & ~busy_r;
  assign rd_fire = fire & ~wr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_addr   <= '0;
      b_addr   <= '0;
      len      <= '0;
      start    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
    end else begin
      start <= 1'b0;
      if (cfg_wr && offset == e_cacc_reg_a_addr) a_addr <= wdata;
      if (cfg_wr && offset == e_cacc_reg_b_addr) b_addr <= wdata;
      if (cfg_wr && offset == e_cacc_reg_len)    len    <= wdata[len_width_p-1:0];
      if (cfg_wr && offset == e_cacc_reg_start) begin
        start  <= 1'b1;
        busy_r <= 1'b1;
        done_r <= 1'b0;
      end
      if (rd_fire && offset == e_cacc_reg_result) done_r <= 1'b0;
      // Completion is placed last so it overrides a same-cycle RESULT read clear.
      if (done && busy_r) begin
        busy_r   <= 1'b0;
        done_r   <= 1'b1;
        result_r <= result;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (offset)
      e_cacc_reg_a_addr: rdata = dword_width_p'(a_addr);
      e_cacc_reg_b_addr: rdata = dword_width_p'(b_addr);
      e_cacc_reg_len:    rdata = dword_width_p'(len);
      e_cacc_reg_status: begin
        rdata[cacc_status_busy_bit] = busy_r;
        rdata[cacc_status_done_bit] = done_r;
      end
      e_cacc_reg_result: rdata = result_r;
      default:           rdata = '0;
    endcase
  end

endmodule

// File: rtl/bp_cacc_io_cfg.sv
// Config front end of the coherent-accelerator tile: accepts one uncached I/O
// command at a time from the I/O CCE and returns its response one cycle later.
module bp_cacc_io_cfg
  import bp_cacc_pkg::*;
#(
  parameter int paddr_width_p   = 40,
  parameter int dword_width_p   = 64,
  parameter int payload_width_p = 16,
  parameter int len_width_p     = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       io_cmd_v_i,
  output logic                       io_cmd_ready_o,
  input  logic                       io_cmd_wr_i,
  input  logic [paddr_width_p-1:0]   io_cmd_addr_i,
  input  logic [dword_width_p-1:0]   io_cmd_data_i,
  input  logic [payload_width_p-1:0] io_cmd_payload_i,
  output logic                       io_resp_v_o,
  input  logic                       io_resp_yumi_i,
  output logic                       io_resp_wr_o,
  output logic [paddr_width_p-1:0]   io_resp_addr_o,
  output logic [dword_width_p-1:0]   io_resp_data_o,
  output logic [payload_width_p-1:0] io_resp_payload_o,
  output logic                       start_o,
  output logic [paddr_width_p-1:0]   a_addr_o,
  output logic [paddr_width_p-1:0]   b_addr_o,
  output logic [len_width_p-1:0]     len_o,
  input  logic                       done_i,
  input  logic [dword_width_p-1:0]   result_i
);

  // Handshakes: a command transfers on a clock edge where io_cmd_v_i and
  // io_cmd_ready_o are both high; a response transfers on an edge where
  // io_resp_v_o and io_resp_yumi_i are both high (yumi only while valid).
  cacc_state_e              state_r, state_n;
  logic                     fire;
  logic [dword_width_p-1:0] rdata;

  assign io_cmd_ready_o = (state_r == e_ready) & ~reset_i;
  assign io_resp_v_o    = (state_r == e_resp);
  assign fire           = io_cmd_v_i & io_cmd_ready_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= e_ready;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_ready: if (fire)           state_n = e_resp;
      e_resp:  if (io_resp_yumi_i) state_n = e_ready;
      default:                     state_n = e_ready;
    endcase
  end

  // Load data is captured at acceptance so later register updates cannot disturb it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      io_resp_wr_o      <= 1'b0;
      io_resp_addr_o    <= '0;
      io_resp_data_o    <= '0;
      io_resp_payload_o <= '0;
    end else if (fire) begin
      io_resp_wr_o      <= io_cmd_wr_i;
      io_resp_addr_o    <= io_cmd_addr_i;
      io_resp_data_o    <= io_cmd_wr_i ? '0 : rdata;
      io_resp_payload_o <= io_cmd_payload_i;
    end
  end

  bp_cacc_io_cfg_regs #(
    .paddr_width_p(paddr_width_p),
    .dword_width_p(dword_width_p),
    .len_width_p  (len_width_p)
  ) regs (
    .clk    (clk_i),
    .reset  (reset_i),
    .fire   (fire),
    .wr     (io_cmd_wr_i),
    .offset (io_cmd_addr_i[7:0]),
    .wdata  (io_cmd_data_i[paddr_width_p-1:0]),
    .rdata  (rdata),
    .start  (start_o),
    .a_addr (a_addr_o),
    .b_addr (b_addr_o),
    .len    (len_o),
    .done   (done_i),
    .result (result_i)
  );

endmodule

// File: tb/tb_bp_cacc_io_cfg.sv
// Bench for bp_cacc_io_cfg: directed commands push expected responses into a
// queue; a monitor pops and compares every response the DUT presents.
module tb_bp_cacc_io_cfg;

  localparam int EW = 1 + 40 + 64 + 16 + 32;
  localparam logic [39:0] BASE = 40'h00_4000_0000;

  logic        clk;
  logic        reset_i;
  logic        io_cmd_v_i;
  logic        io_cmd_ready_o;
  logic        io_cmd_wr_i;
  logic [39:0] io_cmd_addr_i;
  logic [63:0] io_cmd_data_i;
  logic [15:0] io_cmd_payload_i;
  logic        io_resp_v_o;
  logic        io_resp_yumi_i;
  logic        io_resp_wr_o;
  logic [39:0] io_resp_addr_o;
  logic [63:0] io_resp_data_o;
  logic [15:0] io_resp_payload_o;
  logic        start_o;
  logic [39:0] a_addr_o;
  logic [39:0] b_addr_o;
  logic [15:0] len_o;
  logic        done_i;
  logic [63:0] result_i;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hold_cnt = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int last_acc = 0;
  int s0;
  bit resp_seen = 0;
  bit done_at_accept = 0;
  logic [63:0] done_val = '0;

  bp_cacc_io_cfg dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .io_cmd_v_i       (io_cmd_v_i),
    .io_cmd_ready_o   (io_cmd_ready_o),
    .io_cmd_wr_i      (io_cmd_wr_i),
    .io_cmd_addr_i    (io_cmd_addr_i),
    .io_cmd_data_i    (io_cmd_data_i),
    .io_cmd_payload_i (io_cmd_payload_i),
    .io_resp_v_o      (io_resp_v_o),
    .io_resp_yumi_i   (io_resp_yumi_i),
    .io_resp_wr_o     (io_resp_wr_o),
    .io_resp_addr_o   (io_resp_addr_o),
    .io_resp_data_o   (io_resp_data_o),
    .io_resp_payload_o(io_resp_payload_o),
    .start_o          (start_o),
    .a_addr_o         (a_addr_o),
    .b_addr_o         (b_addr_o),
    .len_o            (len_o),
    .done_i           (done_i),
    .result_i         (result_i)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks = checks + 1;
    errors = errors + 1;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // driver
  task automatic send(input logic wr, input logic [7:0] off, input logic [63:0] data,
                      input logic [63:0] exp, input bit wait_resp);
    int n;
    logic [39:0] addr;
    logic [15:0] pl;
    addr = BASE | 40'(off);
    pl = 16'($urandom_range(0, 65535));
    @(negedge clk);
    io_cmd_v_i = 1'b1;
    io_cmd_wr_i = wr;
    io_cmd_addr_i = addr;
    io_cmd_data_i = data;
    io_cmd_payload_i = pl;
    n = 0;
    while (!io_cmd_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!io_cmd_ready_o) begin
      timeout("cmd_accept");
      io_cmd_v_i = 1'b0;
      return;
    end
    exp_q.push_back({wr, addr, exp, pl, 32'(cyc + 1)});
    last_acc = cyc + 1;
    if (done_at_accept) begin
      done_i = 1'b1;
      result_i = done_val;
    end
    @(posedge clk);
    #1;
    io_cmd_v_i = 1'b0;
    done_i = 1'b0;
    done_at_accept = 0;
    if (wait_resp) begin
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (exp_q.size() != 0) timeout("resp_wait");
    end
  endtask

  task automatic pulse_done(input logic [63:0] v);
    @(negedge clk);
    done_i = 1'b1;
    result_i = v;
    @(negedge clk);
    done_i = 1'b0;
  endtask

  always @(negedge clk) if (start_o) begin
    start_cnt = start_cnt + 1;
    start_cyc = cyc;
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset_i) begin
      io_resp_yumi_i = 1'b0;
      resp_seen = 0;
    end else if (io_resp_v_o) begin
      if (exp_q.size() == 0) begin
        timeout("resp_unexpected");
        io_resp_yumi_i = 1'b1;
      end else begin
        e = exp_q[0];
        check("resp_wr",      64'(io_resp_wr_o),      64'(e[152]));
        check("resp_addr",    64'(io_resp_addr_o),    64'(e[151:112]));
        check("resp_data",    io_resp_data_o,         e[111:48]);
        check("resp_payload", 64'(io_resp_payload_o), 64'(e[47:32]));
        if (!resp_seen) check("resp_latency", 64'(cyc), 64'(e[31:0]));
        resp_seen = 1;
        if (hold_cnt > 0) begin
          hold_cnt = hold_cnt - 1;
          check("ready_while_resp", 64'(io_cmd_ready_o), 64'd0);
          io_resp_yumi_i = 1'b0;
        end else begin
          io_resp_yumi_i = 1'b1;
          void'(exp_q.pop_front());
          resp_seen = 0;
        end
      end
    end else begin
      io_resp_yumi_i = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1;
    io_cmd_v_i = 1'b0;
    io_cmd_wr_i = 1'b0;
    io_cmd_addr_i = '0;
    io_cmd_data_i = '0;
    io_cmd_payload_i = '0;
    io_resp_yumi_i = 1'b0;
    done_i = 1'b0;
    result_i = '0;
    #3;
    check("rst_ready",  64'(io_cmd_ready_o), 64'd0);
    check("rst_resp_v", 64'(io_resp_v_o),    64'd0);
    check("rst_start",  64'(start_o),        64'd0);
    check("rst_a",      64'(a_addr_o),       64'd0);
    check("rst_b",      64'(b_addr_o),       64'd0);
    check("rst_len",    64'(len_o),          64'd0);
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    #1;
    check("ready_after_rst", 64'(io_cmd_ready_o), 64'd1);

    // configuration write/read and masking
    send(1, 8'h00, 64'h8000_1000, 64'd0, 1);
    send(0, 8'h00, 64'd0, 64'h8000_1000, 1);
    check("a_addr_o", 64'(a_addr_o), 64'h8000_1000);
    send(1, 8'h10, 64'h1_0010, 64'd0, 1);
    send(0, 8'h10, 64'd0, 64'h0010, 1);
    send(1, 8'h08, 64'hFF00_0012_3456_7890, 64'd0, 1);
    send(0, 8'h08, 64'd0, 64'h12_3456_7890, 1);
    check("b_addr_o", 64'(b_addr_o), 64'h12_3456_7890);

    // start and busy behaviour
    s0 = start_cnt;
    send(1, 8'h18, 64'd1, 64'd0, 1);
    check("start_pulses", 64'(start_cnt - s0), 64'd1);
    check("start_cycle",  64'(start_cyc),      64'(last_acc));
    send(0, 8'h18, 64'd0, 64'd0, 1);
    send(0, 8'h20, 64'd0, 64'h1, 1);
    s0 = start_cnt;
    send(1, 8'h18, 64'd1, 64'd0, 1);
    check("start_busy_nopulse", 64'(start_cnt - s0), 64'd0);
    send(0, 8'h20, 64'd0, 64'h1, 1);
    send(1, 8'h00, 64'h5555, 64'd0, 1);
    send(0, 8'h00, 64'd0, 64'h8000_1000, 1);
    check("a_addr_busy_stable", 64'(a_addr_o), 64'h8000_1000);

    // completion and sticky done
    pulse_done(64'hDEAD_BEEF);
    send(0, 8'h20, 64'd0, 64'h2, 1);
    send(0, 8'h28, 64'd0, 64'hDEAD_BEEF, 1);
    send(0, 8'h20, 64'd0, 64'h0, 1);
    pulse_done(64'h1234);
    send(0, 8'h20, 64'd0, 64'h0, 1);
    send(0, 8'h28, 64'd0, 64'hDEAD_BEEF, 1);

    // unmapped / unaligned offsets
    send(0, 8'h30, 64'd0, 64'd0, 1);
    send(0, 8'h04, 64'd0, 64'd0, 1);
    send(1, 8'h04, 64'hFFFF, 64'd0, 1);
    send(1, 8'h0C, 64'hFFFF, 64'd0, 1);
    send(0, 8'h00, 64'd0, 64'h8000_1000, 1);
    send(0, 8'h08, 64'd0, 64'h12_3456_7890, 1);

    // done_i coincident with RESULT load: old data returned, done set
    send(1, 8'h18, 64'd1, 64'd0, 1);
    done_val = 64'hCAFE;
    done_at_accept = 1;
    send(0, 8'h28, 64'd0, 64'hDEAD_BEEF, 1);
    send(0, 8'h20, 64'd0, 64'h2, 1);
    send(0, 8'h28, 64'd0, 64'hCAFE, 1);
    send(0, 8'h20, 64'd0, 64'h0, 1);

    // response backpressure
    hold_cnt = 5;
    send(0, 8'h10, 64'd0, 64'h0010, 1);

    // reset in the middle of a response
    hold_cnt = 1000;
    send(0, 8'h00, 64'd0, 64'h8000_1000, 0);
    repeat (3) @(negedge clk);
    reset_i = 1'b1;
    #1;
    check("midrst_resp_v", 64'(io_resp_v_o),    64'd0);
    check("midrst_ready",  64'(io_cmd_ready_o), 64'd0);
    check("midrst_a",      64'(a_addr_o),       64'd0);
    check("midrst_b",      64'(b_addr_o),       64'd0);
    check("midrst_len",    64'(len_o),          64'd0);
    exp_q.delete();
    hold_cnt = 0;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    send(0, 8'h00, 64'd0, 64'd0, 1);
    send(0, 8'h08, 64'd0, 64'd0, 1);
    send(0, 8'h10, 64'd0, 64'd0, 1);
    send(0, 8'h20, 64'd0, 64'd0, 1);
    send(0, 8'h28, 64'd0, 64'd0, 1);

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_cacc_io_cfg.md
Name: bp_cacc_io_cfg

Overview:
- Accelerator-side configuration front end of the coherent-accelerator tile. Sits directly downstream of the tile's I/O CCE.
- Consumes uncached I/O command messages (load/store to accelerator CSRs), decodes the dword offset, and updates configuration registers.
- Issues a start pulse to the compute datapath and returns one I/O response per command.
- Tracks busy/done state of the datapath and captures its 64-bit result.

Parameters:
- paddr_width_p, 40, physical address width of I/O command
- dword_width_p, 64, data width of I/O command/response
- payload_width_p, 16, opaque command payload (requesting LCE id etc.), echoed unchanged in response
- len_width_p, 16, vector-length register width

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset; asynchronous, active-high
- io_cmd_v_i  in  1  command valid
- io_cmd_ready_o  out  1  command ready (valid->ready handshake)
- io_cmd_wr_i  in  1  1=uncached store, 0=uncached load
- io_cmd_addr_i  in  paddr_width_p  command address
- io_cmd_data_i  in  dword_width_p  store data
- io_cmd_payload_i  in  payload_width_p  opaque payload
- io_resp_v_o  out  1  response valid
- io_resp_yumi_i  in  1  response consumed (only while io_resp_v_o=1)
- io_resp_wr_o  out  1  echo of command type
- io_resp_addr_o  out  paddr_width_p  echo of command address
- io_resp_data_o  out  dword_width_p  load data; 0 for stores
- io_resp_payload_o  out  payload_width_p  echo of payload
- start_o  out  1  one-cycle start pulse to datapath
- a_addr_o  out  paddr_width_p  vector A base
- b_addr_o  out  paddr_width_p  vector B base
- len_o  out  len_width_p  vector length
- done_i  in  1  datapath completion pulse
- result_i  in  dword_width_p  datapath result, valid with done_i

Behaviour:
- Register map (offset = io_cmd_addr_i[7:0]):
  - 0x00 A_ADDR (rw)
  - 0x08 B_ADDR (rw)
  - 0x10 LEN (rw, low len_width_p bits)
  - 0x18 START (wo; reads return 0)
  - 0x20 STATUS (ro; bit0 busy, bit1 done)
  - 0x28 RESULT (ro)
- Unmapped or unaligned offsets (addr[2:0]!=0): loads return 0, stores are ignored, and a response is still returned.
- Two-state FSM:
  - e_ready: io_cmd_ready_o=1. On v&ready, perform the register effect and latch response fields; go to e_resp.
  - e_resp: io_resp_v_o=1, io_cmd_ready_o=0. On io_resp_yumi_i, go to e_ready.
  - One outstanding command. Response appears exactly 1 cycle after acceptance. Full throughput is 1 command per 2 cycles when yumi is immediate.
- Load data is sampled at acceptance and held stable while io_resp_v_o=1.
- Store to START while busy=0: start_o=1 in the cycle after acceptance; busy<=1; done<=0.
- Store to START while busy=1: ignored. No pulse; response still returned.
- Stores to A_ADDR/B_ADDR/LEN while busy=1 are ignored; outputs stay stable during computation.
- done_i while busy=1: busy<=0, done<=1, result<=result_i. done_i while busy=0 is ignored.
- Load of RESULT clears done (sticky until read). If done_i occurs in the same cycle as a RESULT load, the load returns the old result and done is set (the set wins).
- Store data is masked to field width; upper bits are discarded.
- Reset (async) values:
  - All outputs 0; FSM e_ready is entered after reset deasserts.
  - io_cmd_ready_o=0 while reset_i=1.
  - All registers 0.
  - Reset mid-response drops the pending response.

Decomposition:
- Shared package bp_cacc_pkg holds:
  - register offset localparams (e_cacc_reg_a_addr ... e_cacc_reg_result)
  - FSM state enum
  - STATUS bit positions
- Used by both this block and the vdp datapath.
- One sub-module: bp_cacc_io_cfg_regs (register file plus busy/done/result tracking). The FSM and response latch stay in the top.

Test Plan:
- Store 0x8000_1000 to 0x00, then load 0x00 -> two responses each 1 cycle after accept; load data 0x8000_1000; store response data 0.
- Store LEN=0x1_0010 -> load 0x10 returns 0x0010 (masked to 16 bits).
- Store START -> start_o high exactly one cycle; STATUS=0x1; second START store -> no pulse, STATUS still 0x1.
- done_i with result_i=0xDEAD_BEEF -> STATUS=0x2; RESULT load returns 0xDEAD_BEEF; subsequent STATUS=0x0.
- Load offset 0x30 and 0x04 -> data 0, response returned; no register change.
- Hold io_resp_yumi_i low 5 cycles -> io_cmd_ready_o=0 and response fields stable; assert reset_i mid-response -> io_resp_v_o=0 immediately and all registers read back 0.
